// File: rtl/branch_pkg.sv
// Shared encodings for the branch unit: branch kinds, condition codes,
// flag bit positions, FSM states and the condition evaluator.
package branch_pkg;

  typedef enum logic [1:0] {
    BR_JCC  = 2'd0,
    BR_JMP  = 2'd1,
    BR_CALL = 2'd2,
    BR_RET  = 2'd3
  } br_kind_e;

  // Codes 0-3 keep the legacy jump-decision encoding.
  localparam logic [3:0] CC_EQ = 4'd0,  CC_LT = 4'd1,  CC_LE = 4'd2,  CC_NE = 4'd3;
  localparam logic [3:0] CC_GE = 4'd4,  CC_GT = 4'd5,  CC_CS = 4'd6,  CC_CC = 4'd7;
  localparam logic [3:0] CC_MI = 4'd8,  CC_PL = 4'd9,  CC_VS = 4'd10, CC_VC = 4'd11;
  localparam logic [3:0] CC_HI = 4'd12, CC_LS = 4'd13, CC_AL = 4'd14, CC_NV = 4'd15;

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
    logic s, z, c, v, lt;
    s  = f[FLAG_S];
    z  = f[FLAG_Z];
    c  = f[FLAG_C];
    v  = f[FLAG_V];
    lt = s ^ v;
    case (cc)
      CC_EQ:   cond_eval = z;
      CC_LT:   cond_eval = lt;
      CC_LE:   cond_eval = z | lt;
      CC_NE:   cond_eval = ~z;
      CC_GE:   cond_eval = ~lt;
      CC_GT:   cond_eval = ~z & ~lt;
      CC_CS:   cond_eval = c;
      CC_CC:   cond_eval = ~c;
      CC_MI:   cond_eval = s;
      CC_PL:   cond_eval = ~s;
      CC_VS:   cond_eval = v;
      CC_VC:   cond_eval = ~v;
      CC_HI:   cond_eval = c & ~z;
      CC_LS:   cond_eval = ~c | z;
      CC_AL:   cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module branch_ras
  import branch_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] top_addr,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][ADDR_W-1:0] mem_q, mem_d;
  logic [PW-1:0]                wp_q, wp_d;
  logic [PW:0]                  cnt_q, cnt_d;
  logic [PW-1:0]                rd_idx;

  assign rd_idx   = wp_q - 1'b1;
  assign top_addr = mem_q[rd_idx];
  assign full     = (cnt_q == (PW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);

  // wp always points at the next slot to write, which is the oldest entry once full.
  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wp_q] = push_addr;
      wp_d        = wp_q + 1'b1;
      if (!full) cnt_d = cnt_q + 1'b1;
    end else if (pop && !empty) begin
      wp_d  = rd_idx;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution: flag register with bypass, condition evaluation, RAS for
// CALL/RET, registered PC redirect and a timed flush window.
module branch_unit
  import branch_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int RAS_DEPTH    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flag_we,
  input  logic [3:0]        flag_in,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [1:0]        br_kind,
  input  logic [3:0]        cond,
  input  logic [ADDR_W-1:0] pc_plus1,
  input  logic [ADDR_W-1:0] target,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_next,
  output logic              flush,
  output logic [3:0]        flags_q,
  output logic              ras_err
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  br_kind_e          kind;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              pc_load_q, pc_load_d;
  logic [ADDR_W-1:0] pc_next_q, pc_next_d;
  logic [3:0]        flags_d;
  logic              ras_err_q, ras_err_d;
  logic [3:0]        eff_flags;
  logic              accept, taken, stk_err, push, pop;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_full, ras_empty;

  assign kind      = br_kind_e'(br_kind);
  assign eff_flags = flag_we ? flag_in : flags_q;
  assign br_ready  = (state_q == ST_IDLE);
  assign flush     = (state_q == ST_FLUSH);
  assign accept    = br_valid & br_ready;
  assign pc_load   = pc_load_q;
  assign pc_next   = pc_next_q;
  assign ras_err   = ras_err_q;

  always_comb begin
    taken   = 1'b0;
    stk_err = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    case (kind)
      BR_JCC:  taken = cond_eval(cond, eff_flags);
      BR_JMP:  taken = 1'b1;
      BR_CALL: begin
        taken   = 1'b1;
        push    = accept;
        stk_err = ras_full;
      end
      default: begin
        taken   = ~ras_empty;
        pop     = accept & ~ras_empty;
        stk_err = ras_empty;
      end
    endcase
  end

  branch_ras #(.ADDR_W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_addr (pc_plus1),
    .top_addr  (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_load_d = 1'b0;
    pc_next_d = pc_next_q;
    flags_d   = flag_we ? flag_in : flags_q;
    ras_err_d = ras_err_q | (accept & stk_err);
    case (state_q)
      ST_IDLE: if (accept && taken) begin
        state_d   = ST_FLUSH;
        cnt_d     = CW'(FLUSH_CYCLES - 1);
        pc_load_d = 1'b1;
        pc_next_d = (kind == BR_RET) ? ras_top : target;
      end
      default: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pc_load_q <= 1'b0;
      pc_next_q <= '0;
      flags_q   <= '0;
      ras_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_load_q <= pc_load_d;
      pc_next_q <= pc_next_d;
      flags_q   <= flags_d;
      ras_err_q <= ras_err_d;
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: queue-based reference model checked every
// cycle, plus hand-computed literal expectations.
module tb_branch_unit;
  localparam int AW = 16, DEPTH = 4, FC = 2;

  logic          clk = 1'b0;
  logic          rst, flag_we, br_valid, br_ready, pc_load, flush, ras_err;
  logic [3:0]    flag_in, cond, flags_q;
  logic [1:0]    br_kind;
  logic [AW-1:0] pc_plus1, target, pc_next;

  always #5 clk = ~clk;

  branch_unit #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .flag_we(flag_we), .flag_in(flag_in),
    .br_valid(br_valid), .br_ready(br_ready), .br_kind(br_kind), .cond(cond),
    .pc_plus1(pc_plus1), .target(target), .pc_load(pc_load), .pc_next(pc_next),
    .flush(flush), .flags_q(flags_q), .ras_err(ras_err)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: flags as a nibble, stack as a queue, flush as a countdown.
  logic [3:0]    m_flags;
  logic [AW-1:0] m_stack[$];
  logic          m_err, m_load;
  logic [AW-1:0] m_next;
  int            m_busy;
  bit            chk_en = 0;

  function automatic bit spec_cond(input logic [3:0] cc, input logic [3:0] f);
    bit s, z, c, v;
    {s, z, c, v} = f;
    case (cc)
      0: return z;             1: return s != v;
      2: return z || (s != v); 3: return !z;
      4: return s == v;        5: return !z && (s == v);
      6: return c;             7: return !c;
      8: return s;             9: return !s;
      10: return v;            11: return !v;
      12: return c && !z;      13: return !c || z;
      14: return 1;            default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    bit tk;
    logic [3:0] eff;
    if (rst) begin
      m_flags = 0; m_stack.delete(); m_err = 0; m_busy = 0; m_load = 0; m_next = 0;
    end else begin
      tk  = 0;
      eff = flag_we ? flag_in : m_flags;
      m_load = 0;
      if (br_valid && m_busy == 0) begin
        case (br_kind)
          2'd0: begin tk = spec_cond(cond, eff); if (tk) m_next = target; end
          2'd1: begin tk = 1; m_next = target; end
          2'd2: begin
            tk = 1; m_next = target;
            if (m_stack.size() == DEPTH) begin void'(m_stack.pop_front()); m_err = 1; end
            m_stack.push_back(pc_plus1);
          end
          default: begin
            if (m_stack.size() > 0) begin tk = 1; m_next = m_stack.pop_back(); end
            else m_err = 1;
          end
        endcase
      end
      if (m_busy > 0) m_busy--;
      if (tk) begin m_load = 1; m_busy = FC; end
      if (flag_we) m_flags = flag_in;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_pc_load",  pc_load,  m_load);
      chk("m_pc_next",  pc_next,  m_next);
      chk("m_flush",    flush,    m_busy > 0);
      chk("m_br_ready", br_ready, m_busy == 0);
      chk("m_flags_q",  flags_q,  m_flags);
      chk("m_ras_err",  ras_err,  m_err);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [1:0] k, input logic [3:0] cc, input logic [AW-1:0] pc1,
                       input logic [AW-1:0] tgt, input logic we, input logic [3:0] fin);
    br_valid = 1'b1; br_kind = k; cond = cc; pc_plus1 = pc1; target = tgt;
    flag_we = we; flag_in = fin;
    step();
    br_valid = 1'b0; flag_we = 1'b0;
  endtask

  task automatic set_flags(input logic [3:0] f);
    flag_we = 1'b1; flag_in = f;
    step();
    flag_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flag_we = 0; flag_in = 0; br_valid = 0; br_kind = 0; cond = 0;
    pc_plus1 = 0; target = 0;
    step(); chk_en = 1; step(); rst = 1'b0;
    chk("rst_br_ready", br_ready, 1); chk("rst_flags", flags_q, 0);
    chk("rst_pc_load", pc_load, 0);   chk("rst_flush", flush, 0);
    chk("rst_ras_err", ras_err, 0);   chk("rst_pc_next", pc_next, 0);

    // JCC EQ on Z set
    set_flags(4'b0100);
    issue(2'd0, 4'd0, 16'h0011, 16'h0040, 1'b0, 4'h0);
    chk("eq_pc_load", pc_load, 1); chk("eq_pc_next", pc_next, 16'h0040);
    chk("eq_flush1", flush, 1);    chk("eq_ready1", br_ready, 0);
    step();
    chk("eq_load_pulse", pc_load, 0); chk("eq_flush2", flush, 1); chk("eq_ready2", br_ready, 0);
    step();
    chk("eq_flush_end", flush, 0); chk("eq_ready_back", br_ready, 1);

    // LT taken via bypass; a branch presented during flush is ignored
    issue(2'd0, 4'd1, 16'h0021, 16'h0080, 1'b1, 4'b1000);
    chk("lt_pc_load", pc_load, 1); chk("lt_pc_next", pc_next, 16'h0080);
    issue(2'd1, 4'd0, 16'h0000, 16'h0fff, 1'b0, 4'h0);
    chk("busy_ignored_load", pc_load, 0); chk("busy_flush", flush, 1);
    step();
    // GE not taken with same flags
    issue(2'd0, 4'd4, 16'h0031, 16'h0090, 1'b1, 4'b1000);
    chk("ge_no_load", pc_load, 0); chk("ge_no_flush", flush, 0);
    chk("ge_ready", br_ready, 1);  chk("ge_pc_hold", pc_next, 16'h0080);
    chk("ge_flags", flags_q, 4'b1000);

    // CALL then RET
    issue(2'd2, 4'd0, 16'h0011, 16'h0100, 1'b0, 4'h0);
    chk("call_pc_next", pc_next, 16'h0100);
    step(); step();
    issue(2'd3, 4'd0, 16'h0000, 16'h0000, 1'b0, 4'h0);
    chk("ret_pc_load", pc_load, 1); chk("ret_pc_next", pc_next, 16'h0011);
    chk("ret_err", ras_err, 0);
    step(); step();

    // Overflow: five calls into a four-deep stack
    for (int i = 1; i <= DEPTH + 1; i++) begin
      issue(2'd2, 4'd0, AW'(i), AW'(16'h0200 + i), 1'b0, 4'h0);
      step(); step();
    end
    chk("ovf_err", ras_err, 1);
    for (int i = DEPTH + 1; i >= 2; i--) begin
      issue(2'd3, 4'd0, 16'h0000, 16'h0000, 1'b0, 4'h0);
      chk("ovf_ret_load", pc_load, 1); chk("ovf_ret_pc", pc_next, AW'(i));
      step(); step();
    end
    issue(2'd3, 4'd0, 16'h0000, 16'h0000, 1'b0, 4'h0);
    chk("ovf_extra_ret", pc_load, 0); chk("ovf_extra_flush", flush, 0);

    // RET on empty stack after reset
    do_reset();
    chk("post_rst_err", ras_err, 0);
    issue(2'd3, 4'd0, 16'h0000, 16'h0000, 1'b0, 4'h0);
    chk("empty_ret_load", pc_load, 0); chk("empty_ret_err", ras_err, 1);

    // Reset during the first flush cycle
    do_reset();
    set_flags(4'b0110);
    issue(2'd2, 4'd0, 16'h0077, 16'h0200, 1'b0, 4'h0);
    chk("pre_rst_flush", flush, 1);
    do_reset();
    chk("mid_rst_flush", flush, 0); chk("mid_rst_ready", br_ready, 1);
    chk("mid_rst_flags", flags_q, 0); chk("mid_rst_load", pc_load, 0);
    issue(2'd1, 4'd0, 16'h0000, 16'h0300, 1'b0, 4'h0);
    chk("post_rst_jmp_load", pc_load, 1); chk("post_rst_jmp_pc", pc_next, 16'h0300);
    step(); step();
    issue(2'd3, 4'd0, 16'h0000, 16'h0000, 1'b0, 4'h0);
    chk("stack_emptied", pc_load, 0); chk("stack_emptied_err", ras_err, 1);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
